// File: rtl/axis_unpack.sv
// axis_unpack: AXI-Stream width converter that splits an n-byte input word
// into n single-byte output beats, byte 0 first.
// The optional tlast path is compiled in with `define AXIS_UNPACK_TLAST_EN.
module axis_unpack #(
    parameter  int n  = 4,
    localparam int nb = n * 8
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic [nb-1:0] in_tdata,
    input  logic          in_tvalid,
    output logic          in_tready,
`ifdef AXIS_UNPACK_TLAST_EN
    input  logic          in_tlast,
    output logic          out_tlast,
`endif
    output logic [7:0]    out_tdata,
    output logic          out_tvalid,
    input  logic          out_tready
);

    // Index is at least one bit wide so n=1 still elaborates.
    localparam int iw = (n > 1) ? $clog2(n) : 1;

    typedef enum logic {EMPTY, ACTIVE} state_t;

    state_t              state;
    logic [iw-1:0]       idx;
    logic [n-1:0][7:0]   word;
    logic                at_last;
    logic                load;
    logic                out_fire;
`ifdef AXIS_UNPACK_TLAST_EN
    logic                tlast_q;
`endif

    assign at_last    = (idx == iw'(n - 1));
    assign out_tvalid = (state == ACTIVE);
    assign out_tdata  = word[idx];

    // A new word may enter when idle, or in the same cycle the final byte of
    // the current word leaves, which keeps the output stream bubble-free.
    // Held low during reset so nothing is accepted while state is cleared.
    assign in_tready  = aresetn && ((state == EMPTY) || (at_last && out_tready));

    assign load       = in_tvalid && in_tready;
    assign out_fire   = out_tvalid && out_tready;

`ifdef AXIS_UNPACK_TLAST_EN
    assign out_tlast  = tlast_q && at_last;
`endif

    // Word/index/state sequencing; a load always wins because it can only
    // coincide with the last byte being consumed.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= EMPTY;
            idx     <= '0;
            word    <= '0;
`ifdef AXIS_UNPACK_TLAST_EN
            tlast_q <= 1'b0;
`endif
        end else if (load) begin
            state   <= ACTIVE;
            idx     <= '0;
            word    <= in_tdata;
`ifdef AXIS_UNPACK_TLAST_EN
            tlast_q <= in_tlast;
`endif
        end else if (out_fire) begin
            if (at_last) begin
                state <= EMPTY;
            end else begin
                idx   <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_unpack.sv
// tb_axis_unpack: directed and randomized checks of axis_unpack (n=4) with a
// byte-queue scoreboard. Define AXIS_UNPACK_TLAST_EN to also check tlast.
module tb_axis_unpack;

    localparam int N  = 4;
    localparam int NB = N * 8;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [NB-1:0] in_tdata = '0;
    logic          in_tvalid = 1'b0;
    logic          in_tready;
    logic [7:0]    out_tdata;
    logic          out_tvalid;
    logic          out_tready = 1'b0;
`ifdef AXIS_UNPACK_TLAST_EN
    logic          in_tlast = 1'b0;
    logic          out_tlast;
`endif

    axis_unpack #(.n(N)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
`ifdef AXIS_UNPACK_TLAST_EN
        .in_tlast   (in_tlast),
        .out_tlast  (out_tlast),
`endif
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   nout   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every byte handshake pops the reference queue and compares.
    initial begin
        forever begin
            @(negedge aclk);
            if (aresetn && out_tvalid && out_tready) begin
                nout++;
                if (q.size() == 0) begin
                    check("sb_extra_byte", {24'h0, out_tdata}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("sb_byte", {24'h0, out_tdata}, {24'h0, e.d});
`ifdef AXIS_UNPACK_TLAST_EN
                    check("sb_tlast", {31'h0, out_tlast}, {31'h0, e.l});
`endif
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #300us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer a word until accepted; the reference bytes enter the queue at acceptance.
    task automatic send_word(input logic [NB-1:0] w, input logic l);
        int t;
        bit ok;
        t  = 0;
        ok = 1'b0;
        in_tdata  = w;
        in_tvalid = 1'b1;
`ifdef AXIS_UNPACK_TLAST_EN
        in_tlast  = l;
`endif
        while (!ok && t < 2000) begin
            @(negedge aclk);
            if (in_tready) begin
                ok = 1'b1;
                for (int k = 0; k < N; k++) begin
                    exp_t e;
                    e.d = w[k*8 +: 8];
                    e.l = l && (k == N - 1);
                    q.push_back(e);
                end
            end
            @(posedge aclk);
            #1;
            t++;
        end
        in_tvalid = 1'b0;
        check("send_accept", {31'h0, ok}, 32'h1);
    endtask

    task automatic cycles(input int c);
        repeat (c) begin
            @(posedge aclk);
            #1;
        end
    endtask

    // Expects the word just accepted to appear on the next 4 cycles with out_tready=1.
    task automatic check_word(input logic [NB-1:0] w, input string tag);
        for (int i = 0; i < N; i++) begin
            @(negedge aclk);
            check({tag, "_valid"}, {31'h0, out_tvalid}, 32'h1);
            check({tag, "_data"}, {24'h0, out_tdata}, {24'h0, w[i*8 +: 8]});
            check({tag, "_in_tready"}, {31'h0, in_tready}, {31'h0, (i == N - 1)});
        end
        @(negedge aclk);
        check({tag, "_idle"}, {31'h0, out_tvalid}, 32'h0);
        @(posedge aclk);
        #1;
    endtask

    initial begin
        logic [NB-1:0] w;
        int   c;
        int   n0;
        int   k;
        bit   rdone;
        time  t0;

        // Reset state
        #2;
        check("rst_out_tvalid", {31'h0, out_tvalid}, 32'h0);
        check("rst_out_tdata", {24'h0, out_tdata}, 32'h0);
        check("rst_in_tready", {31'h0, in_tready}, 32'h0);
`ifdef AXIS_UNPACK_TLAST_EN
        check("rst_out_tlast", {31'h0, out_tlast}, 32'h0);
`endif
        cycles(3);
        aresetn    = 1'b1;
        out_tready = 1'b1;
        cycles(1);
        check("idle_in_tready", {31'h0, in_tready}, 32'h1);

        // Single word with 1-cycle latency
        send_word(32'h44434241, 1'b0);
        check_word(32'h44434241, "single");

        // Back-to-back words without an output gap; tlast only on byte 8
        fork
            begin
                send_word(32'h44434241, 1'b0);
                send_word(32'h48474645, 1'b1);
            end
            begin
                k = 0;
                @(negedge aclk);
                while (!out_tvalid && k < 10) begin
                    @(negedge aclk);
                    k++;
                end
                check("b2b_start", {31'h0, out_tvalid}, 32'h1);
                for (int i = 0; i < 8; i++) begin
                    if (i > 0) @(negedge aclk);
                    check("b2b_valid", {31'h0, out_tvalid}, 32'h1);
                    check("b2b_data", {24'h0, out_tdata}, 32'h41 + i);
`ifdef AXIS_UNPACK_TLAST_EN
                    check("b2b_tlast", {31'h0, out_tlast}, {31'h0, (i == 7)});
`endif
                end
            end
        join
        cycles(3);
        check("b2b_drained", q.size(), 0);

        // Backpressure while byte 42 is shown
        send_word(32'h44434241, 1'b0);
        @(posedge aclk);
        #1;
        out_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("bp_hold_valid", {31'h0, out_tvalid}, 32'h1);
            check("bp_hold_data", {24'h0, out_tdata}, 32'h42);
            check("bp_hold_in_tready", {31'h0, in_tready}, 32'h0);
            @(posedge aclk);
            #1;
        end
        out_tready = 1'b1;
        @(negedge aclk);
        check("bp_release_data", {24'h0, out_tdata}, 32'h42);
        @(negedge aclk);
        check("bp_resume_data", {24'h0, out_tdata}, 32'h43);
        cycles(4);

        // Reset after byte 41 is consumed
        send_word(32'h44434241, 1'b0);
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        q.delete();
        #1;
        check("midrst_out_tvalid", {31'h0, out_tvalid}, 32'h0);
        check("midrst_out_tdata", {24'h0, out_tdata}, 32'h0);
        check("midrst_in_tready", {31'h0, in_tready}, 32'h0);
        cycles(2);
        aresetn = 1'b1;
        cycles(1);
        send_word(32'h58575655, 1'b0);
        check_word(32'h58575655, "post_rst");

        // Randomized run: 500 words of 'A'..'Z' with input pauses and output stalls
        c     = 0;
        rdone = 1'b0;
        n0    = nout;
        t0    = $time;
        fork
            begin
                for (int wi = 0; wi < 500; wi++) begin
                    for (int b = 0; b < N; b++) begin
                        w[b*8 +: 8] = 8'h41 + 8'(c % 26);
                        c++;
                    end
                    cycles($urandom_range(0, 3));
                    send_word(w, 1'($urandom_range(0, 1)));
                end
                k = 0;
                while (q.size() != 0 && k < 500) begin
                    cycles(1);
                    k++;
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    out_tready = 1'b0;
                    cycles($urandom_range(1, 6));
                    out_tready = 1'b1;
                    cycles($urandom_range(1, 8));
                end
            end
        join
        out_tready = 1'b1;
        cycles(2);
        check("rand_bytes_out", nout - n0, 2000);
        check("rand_queue_empty", q.size(), 0);
        check("rand_within_100us", {31'h0, (($time - t0) < 100us)}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_unpack.md
AXIS_UNPACK -- requirements
Module: axis_unpack

Interface
REQ-001 The block SHALL have parameter n, default 4, giving bytes per input word; legal range 1..16.
REQ-002 The block SHALL have localparam nb = n*8, the input data width.
REQ-003 aclk  input  1  sole clock; all state updates on its rising edge.
REQ-004 aresetn  input  1  asynchronous active-low reset.
REQ-005 in_tdata  input  nb  AXI-Stream input word; byte k is in_tdata[k*8+:8].
REQ-006 in_tvalid  input  1  input word valid.
REQ-007 in_tready  output  1  block accepts the input word.
REQ-008 in_tlast  input  1  end-of-packet marker; present only with AXIS_UNPACK_TLAST_EN.
REQ-009 out_tdata  output  8  AXI-Stream output byte.
REQ-010 out_tvalid  output  1  output byte valid.
REQ-011 out_tready  input  1  downstream accepts the byte.
REQ-012 out_tlast  output  1  last byte of a packet; present only with AXIS_UNPACK_TLAST_EN.

Function
REQ-013 The block SHALL split each accepted n-byte word into n output bytes, byte 0 first and byte n-1 last.
REQ-014 An input transfer SHALL occur on a rising edge where in_tvalid and in_tready are both 1; an output transfer SHALL occur on a rising edge where out_tvalid and out_tready are both 1.
REQ-015 Internal state SHALL be a word register, a byte index idx (0..n-1) and a state of EMPTY or ACTIVE, where out_tvalid = (state==ACTIVE).
REQ-016 in_tready SHALL be combinational: 1 when state==EMPTY, or when idx==n-1 and out_tready==1; otherwise 0.
REQ-017 EMPTY to ACTIVE: on an input transfer, load the word, set idx=0 and present byte 0 in the next cycle (1-cycle latency).
REQ-018 ACTIVE with idx<n-1: an output transfer SHALL increment idx; without a transfer, out_tdata, idx and out_tvalid SHALL hold.
REQ-019 ACTIVE with idx==n-1: on an output transfer with a simultaneous input transfer, load the new word with idx=0 and stay ACTIVE, so no bubble occurs; on an output transfer alone, go to EMPTY.
REQ-020 out_tdata SHALL equal word[idx*8+:8] and SHALL be stable while out_tvalid=1 and out_tready=0.
REQ-021 Sustained throughput SHALL be 1 byte per cycle when in_tvalid=1 and out_tready=1 continuously; in_tready SHALL be high 1 cycle in n.
REQ-022 With n=1, the block SHALL behave as a single full-throughput register stage.
REQ-023 Input bytes SHALL never be dropped, duplicated or reordered, under any pattern of in_tvalid and out_tready.

Reset
REQ-024 While aresetn=0, state SHALL be EMPTY, idx=0, word register 0, out_tvalid=0, out_tdata=8'h00, out_tlast=0, and in_tready SHALL be forced to 0.
REQ-025 Reset asserted mid-word SHALL discard the remaining bytes; after release, the first accepted word SHALL start at byte 0.

Configuration
REQ-026 The macro AXIS_UNPACK_TLAST_EN, when defined, SHALL add in_tlast and out_tlast: in_tlast is registered with the word, and out_tlast = stored tlast AND idx==n-1.
REQ-027 Without AXIS_UNPACK_TLAST_EN, the in_tlast and out_tlast ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (n=4)
REQ-028 Single word: in_tdata=32'h44434241 with out_tready=1 -> bytes 41,42,43,44 on 4 consecutive cycles starting 1 cycle after the transfer, and in_tready=0 for the first 3 of them.
REQ-029 Back-to-back: words 32'h44434241 and 32'h48474645 with in_tvalid=1 and out_tready=1 -> 8 contiguous bytes 41..48 with no out_tvalid gap.
REQ-030 Backpressure: out_tready=0 for 3 cycles while byte 42 is shown -> out_tdata=42 and out_tvalid=1 held stable, then the sequence resumes with 43.
REQ-031 Reset mid-word: aresetn low after byte 41 is consumed -> out_tvalid=0 immediately; the next word 32'h58575655 then yields 55,56,57,58.
REQ-032 Random run: 500 words of bytes cycling 'A'..'Z', input pauses of 0-3 cycles, out_tready low for random 1-6 cycle bursts, byte-queue scoreboard -> 2000 bytes out and 0 errors before a 100 us timeout.
REQ-033 With AXIS_UNPACK_TLAST_EN: two words with in_tlast=0 then 1 -> out_tlast=1 only on the 8th byte.
